ld_st_unit: RTL and testbench

Memory stage directly downstream of adr_add in the Loopers out-of-order core. It takes each load/store whose effective address adr_add has just computed, along with store data and the ROB tag. It keeps stores in an in-order store queue until the ROB commits them, then drains committed stores to data memory one per cycle. Loads access data memory or are forwarded from the queue, and every accepted op reports completion to the ROB one cycle after acceptance.

---
 rtl/loopers_pkg.sv | 18 +
 rtl/lsu_sq_fwd.sv | 33 +++
 rtl/ld_st_unit.sv | 172 +++++++++++++++++
 tb/tb_ld_st_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loopers_pkg.sv
// Shared types and widths for the Loopers memory stage.
// Store-queue entry layout lives here so every unit agrees on it.
package loopers_pkg;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 16;
  localparam int TAG_W_DEF    = 6;
  localparam int SQ_DEPTH_DEF = 4;

  // Queue slot; the ROB tag is not stored because every op
  // reports completion the cycle after it is accepted.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              cmt;
  } sq_entry_t;

endpackage

// File: rtl/lsu_sq_fwd.sv
// Youngest-match selector for store-to-load forwarding.
// Scans oldest to youngest from head; the last hit wins.
module lsu_sq_fwd
  import loopers_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH_DEF,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             vld,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
  input  logic [IW-1:0]                head,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         hit,
  output logic [IW-1:0]                hit_idx
);

  logic [IW-1:0] idx;

  // Age-ordered walk so a younger match overrides an older one
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + IW'(k);
      if (vld[idx] && (addrs[idx] == ld_addr)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

endmodule

// File: rtl/ld_st_unit.sv
// Load/store stage: in-order store queue, commit tracking,
// drain to data memory and store-to-load forwarding.
module ld_st_unit
  import loopers_pkg::*;
#(
  parameter int SQ_DEPTH = SQ_DEPTH_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              mem_vld,
  input  logic              mem_ld,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_st_data,
  input  logic [TAG_W-1:0]  mem_tag,
  output logic              mem_rdy,
  input  logic              st_cmt,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              cmp_vld,
  output logic [TAG_W-1:0]  cmp_tag,
  output logic              cmp_is_ld,
  output logic [DATA_W-1:0] cmp_data,
  output logic              sq_full,
  output logic              sq_empty
);

  localparam int IW = $clog2(SQ_DEPTH);
  localparam int PW = IW + 1;

  sq_entry_t q [SQ_DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] cmt_ptr;
  logic [PW-1:0] tail;
  logic [PW-1:0] cmt_nxt;
  logic [PW-1:0] occ;
  logic [PW-1:0] off;

  logic [SQ_DEPTH-1:0]             vld;
  logic [SQ_DEPTH-1:0][ADDR_W-1:0] addrs;

  logic          hit;
  logic [IW-1:0] hit_idx;

  sq_entry_t hd;

  logic acc;
  logic st_acc;
  logic ld_acc;
  logic ld_mem;
  logic cmt_ok;
  logic drain;

  logic              cmp_vld_q;
  logic              src_mem;
  logic [DATA_W-1:0] ld_data;

  assign occ      = tail - head;
  assign sq_empty = (head == tail);
  assign sq_full  = (head[IW-1:0] == tail[IW-1:0])
                  & (head[IW] != tail[IW]);
  assign mem_rdy  = ~sq_full;

  assign acc    = rst_n & mem_vld & mem_rdy & ~flush;
  assign st_acc = acc & ~mem_ld;
  assign ld_acc = acc & mem_ld;
  assign ld_mem = ld_acc & ~hit;

  // Only entries already queued can be committed this cycle
  assign cmt_ok  = st_cmt & (cmt_ptr != tail);
  assign cmt_nxt = cmt_ok ? cmt_ptr + PW'(1) : cmt_ptr;

  assign hd    = q[head[IW-1:0]];
  assign drain = ~sq_empty & hd.cmt & ~ld_mem;

  // Slot valid when its age offset from head is below occupancy
  always_comb begin
    vld   = '0;
    addrs = '0;
    off   = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      off      = {1'b0, IW'(i) - head[IW-1:0]};
      vld[i]   = (off < occ);
      addrs[i] = q[i].addr;
    end
  end

  lsu_sq_fwd #(
    .DEPTH (SQ_DEPTH),
    .IW    (IW)
  ) u_fwd (
    .vld     (vld),
    .addrs   (addrs),
    .head    (head[IW-1:0]),
    .ld_addr (mem_addr),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  // Memory port: an unforwarded load takes it ahead of drain
  always_comb begin
    dmem_re    = ld_mem;
    dmem_we    = drain;
    dmem_addr  = '0;
    dmem_wdata = '0;
    if (ld_mem) begin
      dmem_addr = mem_addr;
    end else if (drain) begin
      dmem_addr  = hd.addr;
      dmem_wdata = hd.data;
    end
  end

  // Queue pointers and entries; flush rewinds tail to commit point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      cmt_ptr <= '0;
      tail    <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      if (drain) begin
        head <= head + PW'(1);
      end
      cmt_ptr <= cmt_nxt;
      if (flush) begin
        tail <= cmt_nxt;
      end else if (st_acc) begin
        tail <= tail + PW'(1);
      end
      if (st_acc) begin
        q[tail[IW-1:0]] <= '{
          addr: mem_addr,
          data: mem_st_data,
          cmt:  1'b0
        };
      end
      if (cmt_ok) begin
        q[cmt_ptr[IW-1:0]].cmt <= 1'b1;
      end
    end
  end

  // Completion bundle registered one cycle after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_vld_q <= 1'b0;
      cmp_tag   <= '0;
      cmp_is_ld <= 1'b0;
      src_mem   <= 1'b0;
      ld_data   <= '0;
    end else begin
      cmp_vld_q <= acc;
      cmp_tag   <= acc ? mem_tag : '0;
      cmp_is_ld <= ld_acc;
      src_mem   <= ld_mem;
      ld_data   <= (ld_acc & hit) ? q[hit_idx].data : '0;
    end
  end

  // A flush kills the completion of last cycle's op as it emerges
  assign cmp_vld  = cmp_vld_q & ~flush;
  assign cmp_data = src_mem ? dmem_rdata : ld_data;

endmodule

// File: tb/tb_ld_st_unit.sv
// Directed bench for ld_st_unit.
// Memory model returns addr ^ 0x5A6A one cycle after a read.
module tb_ld_st_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        mem_vld;
  logic        mem_ld;
  logic [15:0] mem_addr;
  logic [15:0] mem_st_data;
  logic [5:0]  mem_tag;
  logic        mem_rdy;
  logic        st_cmt;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_we;
  logic        dmem_re;
  logic [15:0] dmem_rdata;
  logic        cmp_vld;
  logic [5:0]  cmp_tag;
  logic        cmp_is_ld;
  logic [15:0] cmp_data;
  logic        sq_full;
  logic        sq_empty;

  int errors = 0;
  int checks = 0;
  int pend   = 0;

  ld_st_unit #(.SQ_DEPTH(4), .TAG_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .mem_vld     (mem_vld),
    .mem_ld      (mem_ld),
    .mem_addr    (mem_addr),
    .mem_st_data (mem_st_data),
    .mem_tag     (mem_tag),
    .mem_rdy     (mem_rdy),
    .st_cmt      (st_cmt),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_we     (dmem_we),
    .dmem_re     (dmem_re),
    .dmem_rdata  (dmem_rdata),
    .cmp_vld     (cmp_vld),
    .cmp_tag     (cmp_tag),
    .cmp_is_ld   (cmp_is_ld),
    .cmp_data    (cmp_data),
    .sq_full     (sq_full),
    .sq_empty    (sq_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial dmem_rdata = 16'h0000;
  always @(posedge clk) begin
    if (dmem_re) dmem_rdata <= dmem_addr ^ 16'h5A6A;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 0;
    end else begin
      assert (!(st_cmt && pend == 0)) else begin
        errors++;
        $error("FAIL st_cmt_protocol: pend=%0d need >0", pend);
      end
      if (flush) pend <= 0;
      else pend <= pend - int'(st_cmt)
                 + int'(mem_vld && !mem_ld && mem_rdy);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_vld = 1'b0;
    mem_ld  = 1'b0;
    st_cmt  = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic st(input logic [15:0] a,
                    input logic [15:0] d,
                    input logic [5:0]  t);
    mem_vld     = 1'b1;
    mem_ld      = 1'b0;
    mem_addr    = a;
    mem_st_data = d;
    mem_tag     = t;
  endtask

  task automatic ld(input logic [15:0] a,
                    input logic [5:0]  t);
    mem_vld  = 1'b1;
    mem_ld   = 1'b1;
    mem_addr = a;
    mem_tag  = t;
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_addr    = '0;
    mem_st_data = '0;
    mem_tag     = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmp_vld", cmp_vld, 0);
    chk("rst_cmp_tag", cmp_tag, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_re", dmem_re, 0);
    chk("rst_empty", sq_empty, 1);
    chk("rst_full", sq_full, 0);
    chk("rst_rdy", mem_rdy, 1);
    rst_n = 1'b1;
    tick();

    // forwarding from a single store
    idle(); st(16'h0010, 16'hBEEF, 6'd3); #1;
    chk("t1_st_re", dmem_re, 0);
    tick();
    chk("t1_st_vld", cmp_vld, 1);
    chk("t1_st_tag", cmp_tag, 3);
    chk("t1_st_isld", cmp_is_ld, 0);
    chk("t1_st_data", cmp_data, 0);
    idle(); ld(16'h0010, 6'd4); #1;
    chk("t1_ld_re", dmem_re, 0);
    tick();
    chk("t1_ld_vld", cmp_vld, 1);
    chk("t1_ld_tag", cmp_tag, 4);
    chk("t1_ld_isld", cmp_is_ld, 1);
    chk("t1_ld_data", cmp_data, 16'hBEEF);
    idle(); st_cmt = 1'b1; #1;
    chk("t1_cmt_re", dmem_re, 0);
    tick();
    idle(); #1;
    chk("t1_dr_we", dmem_we, 1);
    chk("t1_dr_addr", dmem_addr, 16'h0010);
    chk("t1_dr_wdata", dmem_wdata, 16'hBEEF);
    tick();
    chk("t1_empty", sq_empty, 1);

    // youngest of two matching stores wins
    idle(); st(16'h0020, 16'h1111, 6'd5); tick();
    idle(); st(16'h0020, 16'h2222, 6'd6); tick();
    idle(); ld(16'h0020, 6'd7); #1;
    chk("t2_re", dmem_re, 0);
    tick();
    chk("t2_tag", cmp_tag, 7);
    chk("t2_data", cmp_data, 16'h2222);
    idle(); st_cmt = 1'b1; #1;
    chk("t2_we0", dmem_we, 0);
    tick();
    chk("t2_we1", dmem_we, 1);
    chk("t2_wd1", dmem_wdata, 16'h1111);
    tick();
    idle(); #1;
    chk("t2_we2", dmem_we, 1);
    chk("t2_wd2", dmem_wdata, 16'h2222);
    tick();
    chk("t2_empty", sq_empty, 1);

    // unforwarded load from memory
    idle(); ld(16'h0030, 6'd8); #1;
    chk("t3_re", dmem_re, 1);
    chk("t3_addr", dmem_addr, 16'h0030);
    chk("t3_we", dmem_we, 0);
    tick();
    idle(); #1;
    chk("t3_vld", cmp_vld, 1);
    chk("t3_tag", cmp_tag, 8);
    chk("t3_isld", cmp_is_ld, 1);
    chk("t3_data", cmp_data, 16'h5A5A);

    // fill, full stall, wrap and in-order drain
    for (int i = 0; i < 4; i++) begin
      idle();
      st(16'h0100 + 16'(i), 16'hA000 + 16'(i), 6'(10 + i));
      tick();
    end
    idle(); #1;
    chk("t4_full", sq_full, 1);
    chk("t4_rdy", mem_rdy, 0);
    chk("t4_empty", sq_empty, 0);
    st_cmt = 1'b1; #1;
    chk("t4_we0", dmem_we, 0);
    tick();
    chk("t4_we_a", dmem_we, 1);
    chk("t4_addr_a", dmem_addr, 16'h0100);
    chk("t4_wd_a", dmem_wdata, 16'hA000);
    chk("t4_rdy_a", mem_rdy, 0);
    tick();
    idle(); st(16'h0104, 16'hA004, 6'd14); #1;
    chk("t4_we_b", dmem_we, 1);
    chk("t4_addr_b", dmem_addr, 16'h0101);
    chk("t4_wd_b", dmem_wdata, 16'hA001);
    chk("t4_rdy_b", mem_rdy, 1);
    tick();
    idle(); st(16'h0105, 16'hA005, 6'd15); #1;
    chk("t4_we_c", dmem_we, 0);
    chk("t4_tag_c", cmp_tag, 14);
    tick();
    for (int i = 0; i < 5; i++) begin
      idle();
      st_cmt = (i < 4);
      #1;
      if (i > 0) begin
        chk("t4_wrap_we", dmem_we, 1);
        chk("t4_wrap_addr", dmem_addr, 16'h0101 + 16'(i));
        chk("t4_wrap_wd", dmem_wdata, 16'hA001 + 16'(i));
      end
      tick();
    end
    idle(); #1;
    chk("t4_end_empty", sq_empty, 1);
    chk("t4_end_we", dmem_we, 0);

    // flush keeps the committed store only
    idle(); st(16'h0200, 16'hB000, 6'd20); tick();
    idle(); st(16'h0201, 16'hB001, 6'd21); tick();
    idle(); st(16'h0202, 16'hB002, 6'd22); st_cmt = 1'b1; #1;
    chk("t5_we0", dmem_we, 0);
    chk("t5_vld_s1", cmp_vld, 1);
    chk("t5_tag_s1", cmp_tag, 21);
    tick();
    idle(); flush = 1'b1; st(16'h02FF, 16'hFFFF, 6'd23); #1;
    chk("t5_kill_vld", cmp_vld, 0);
    chk("t5_dr_we", dmem_we, 1);
    chk("t5_dr_addr", dmem_addr, 16'h0200);
    chk("t5_dr_wd", dmem_wdata, 16'hB000);
    tick();
    idle(); #1;
    chk("t5_drop_vld", cmp_vld, 0);
    chk("t5_empty", sq_empty, 1);
    chk("t5_we1", dmem_we, 0);
    tick();
    chk("t5_we2", dmem_we, 0);

    // load beats drain; then reset mid-drain
    idle(); st(16'h0050, 16'hC000, 6'd30); tick();
    idle(); st_cmt = 1'b1; tick();
    idle(); ld(16'h0040, 6'd31); #1;
    chk("t6_re", dmem_re, 1);
    chk("t6_we", dmem_we, 0);
    chk("t6_addr", dmem_addr, 16'h0040);
    tick();
    idle(); #1;
    chk("t6_ld_vld", cmp_vld, 1);
    chk("t6_ld_tag", cmp_tag, 31);
    chk("t6_ld_data", cmp_data, 16'h5A2A);
    chk("t6_dr_we", dmem_we, 1);
    chk("t6_dr_addr", dmem_addr, 16'h0050);
    chk("t6_dr_wd", dmem_wdata, 16'hC000);
    rst_n = 1'b0; #1;
    chk("t6_rst_we", dmem_we, 0);
    chk("t6_rst_vld", cmp_vld, 0);
    chk("t6_rst_re", dmem_re, 0);
    chk("t6_rst_empty", sq_empty, 1);
    chk("t6_rst_rdy", mem_rdy, 1);
    tick();
    rst_n = 1'b1; #1;
    chk("t6_post_we", dmem_we, 0);
    tick();
    chk("t6_post_vld", cmp_vld, 0);
    chk("t6_post_we2", dmem_we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
